// File: rtl/debounce_bank_if.sv
// Signal bundle between the debounce bank and its consumer (MCU port logic).
// The consumer side (master) drives the raw buttons and the acknowledge
// strobes; the debouncer side (slave) returns levels, strobes, flags and IRQ.
interface debounce_bank_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] PB;
  logic [CHANNELS-1:0] ACK;
  logic [CHANNELS-1:0] PB_state;
  logic [CHANNELS-1:0] PB_down;
  logic [CHANNELS-1:0] PB_up;
  logic [CHANNELS-1:0] EV_down;
  logic [CHANNELS-1:0] EV_up;
  logic                IRQ;

  modport master (
    output PB, ACK,
    input  PB_state, PB_down, PB_up, EV_down, EV_up, IRQ
  );

  modport slave (
    input  PB, ACK,
    output PB_state, PB_down, PB_up, EV_down, EV_up, IRQ
  );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel push-button debouncer. Each channel synchronises its raw
// input, requires 2^DELAY stable ticks before flipping its clean level, and
// emits one-cycle press/release strobes. Sticky event flags (write-1-to-clear
// via ACK, set wins over clear) feed a registered IRQ. A shared prescaler
// slows the tick so long windows need no wider counters.
module debounce_bank #(
  parameter int                  CHANNELS = 8,
  parameter int                  DELAY    = 16,
  parameter int                  PRESCALE = 0,
  parameter logic [CHANNELS-1:0] INVERT   = {CHANNELS{1'b1}}
) (
  input  logic             CLK,
  input  logic             RSTdash,
  debounce_bank_if.slave   bus
);

  localparam logic [DELAY-1:0] CNT_MAX = {DELAY{1'b1}};

  logic [CHANNELS-1:0] s0;
  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] state_q;
  logic [CHANNELS-1:0] down_q;
  logic [CHANNELS-1:0] up_q;
  logic [CHANNELS-1:0] ev_down_q;
  logic [CHANNELS-1:0] ev_up_q;
  logic                irq_q;
  logic [DELAY-1:0]    cnt_q [CHANNELS];
  logic                tick;

  generate
    if (PRESCALE == 0) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      logic [PRESCALE-1:0] pre_cnt;

      // Free-running prescaler; ticks once per wrap, shared by every channel.
      always_ff @(posedge CLK or negedge RSTdash) begin
        if (!RSTdash) pre_cnt <= '0;
        else          pre_cnt <= pre_cnt + 1'b1;
      end

      assign tick = &pre_cnt;
    end
  endgenerate

  // Synchronisers, debounce counters, clean level and edge strobes.
  always_ff @(posedge CLK or negedge RSTdash) begin
    if (!RSTdash) begin
      s0      <= '0;
      s1      <= '0;
      state_q <= '0;
      down_q  <= '0;
      up_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      s0     <= bus.PB ^ INVERT;
      s1     <= s0;
      down_q <= '0;
      up_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        // A channel whose synced input matches its level restarts the window,
        // so any bounce back before the window completes is ignored.
        if (s1[i] == state_q[i]) begin
          cnt_q[i] <= '0;
        end else if (tick) begin
          if (cnt_q[i] == CNT_MAX) begin
            cnt_q[i]   <= '0;
            state_q[i] <= ~state_q[i];
            down_q[i]  <= s1[i];
            up_q[i]    <= ~s1[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  // Sticky event flags: a strobe sets, ACK clears, set wins on collision.
  always_ff @(posedge CLK or negedge RSTdash) begin
    if (!RSTdash) begin
      ev_down_q <= '0;
      ev_up_q   <= '0;
    end else begin
      ev_down_q <= down_q | (ev_down_q & ~bus.ACK);
      ev_up_q   <= up_q   | (ev_up_q   & ~bus.ACK);
    end
  end

  // Interrupt follows the flags with one cycle of lag.
  always_ff @(posedge CLK or negedge RSTdash) begin
    if (!RSTdash) irq_q <= 1'b0;
    else          irq_q <= |(ev_down_q | ev_up_q);
  end

  assign bus.PB_state = state_q;
  assign bus.PB_down  = down_q;
  assign bus.PB_up    = up_q;
  assign bus.EV_down  = ev_down_q;
  assign bus.EV_up    = ev_up_q;
  assign bus.IRQ      = irq_q;

endmodule
